// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Packs abstract instruction commands (format class, register
//               fields, funct, immediate) into 32-bit RV32I instruction words
//               and queues them in a small registered FIFO for the debug/boot
//               injection port. Illegal commands are dropped, flagged with a
//               one-cycle err pulse and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_fmt,
    input  logic [4:0]       cmd_rd,
    input  logic [4:0]       cmd_rs1,
    input  logic [4:0]       cmd_rs2,
    input  logic [2:0]       cmd_funct3,
    input  logic [6:0]       cmd_funct7,
    input  logic [31:0]      cmd_imm,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic             err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int                 c_ADDR_W   = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0]  c_FULL_CNT = (c_ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [6:0] c_OP_R       = 7'b0110011;
    localparam logic [6:0] c_OP_I_JUMP  = 7'b1100111;
    localparam logic [6:0] c_OP_I_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_I_ARITH = 7'b0010011;
    localparam logic [6:0] c_OP_I_SYS   = 7'b1110011;
    localparam logic [6:0] c_OP_I_FENCE = 7'b0001111;
    localparam logic [6:0] c_OP_S       = 7'b0100011;
    localparam logic [6:0] c_OP_B       = 7'b1100011;
    localparam logic [6:0] c_OP_LUI     = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] c_OP_J       = 7'b1101111;

    logic [31:0]         r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic [31:0]         r_last;
    logic                r_err;
    logic [CNT_W-1:0]    r_enc_count;
    logic [CNT_W-1:0]    r_err_count;

    logic [31:0]         w_word;
    logic                w_legal;
    logic                w_imm12_ok;
    logic                w_imm13_ok;
    logic                w_imm21_ok;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;

    // Immediate range checks: the bits above the encodable field must be a
    // pure sign extension of the field's top bit.
    assign w_imm12_ok = (&cmd_imm[31:11]) | ~(|cmd_imm[31:11]);
    assign w_imm13_ok = ((&cmd_imm[31:12]) | ~(|cmd_imm[31:12])) & ~cmd_imm[0];
    assign w_imm21_ok = ((&cmd_imm[31:20]) | ~(|cmd_imm[31:20])) & ~cmd_imm[0];

    // Encode the command word and decide its legality per format class.
    always_comb begin
        w_word  = 32'd0;
        w_legal = 1'b1;
        case (cmd_fmt)
            4'd0: w_word = {cmd_funct7, cmd_rs2, cmd_rs1, cmd_funct3, cmd_rd, c_OP_R};
            4'd1: begin
                w_word  = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, c_OP_I_JUMP};
                w_legal = w_imm12_ok;
            end
            4'd2: begin
                w_word  = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, c_OP_I_LOAD};
                w_legal = w_imm12_ok;
            end
            4'd3: begin
                w_word  = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, c_OP_I_ARITH};
                w_legal = w_imm12_ok;
            end
            4'd4: begin
                w_word  = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, c_OP_I_SYS};
                w_legal = w_imm12_ok;
            end
            4'd5: begin
                w_word  = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, c_OP_I_FENCE};
                w_legal = w_imm12_ok;
            end
            4'd6: begin
                w_word  = {cmd_imm[11:5], cmd_rs2, cmd_rs1, cmd_funct3, cmd_imm[4:0], c_OP_S};
                w_legal = w_imm12_ok;
            end
            4'd7: begin
                w_word  = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, cmd_funct3,
                           cmd_imm[4:1], cmd_imm[11], c_OP_B};
                w_legal = w_imm13_ok;
            end
            4'd8: begin
                w_word  = {cmd_imm[31:12], cmd_rd, c_OP_LUI};
                w_legal = ~(|cmd_imm[11:0]);
            end
            4'd9: begin
                w_word  = {cmd_imm[31:12], cmd_rd, c_OP_AUIPC};
                w_legal = ~(|cmd_imm[11:0]);
            end
            4'd10: begin
                w_word  = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12],
                           cmd_rd, c_OP_J};
                w_legal = w_imm21_ok;
            end
            default: begin
                w_word  = 32'd0;
                w_legal = 1'b0;
            end
        endcase
    end

    // Full FIFO stalls the command side even if the head is popped this cycle.
    assign cmd_ready   = (r_count < c_FULL_CNT);
    assign instr_valid = (r_count != '0);
    assign w_accept    = cmd_valid & cmd_ready;
    assign w_push      = w_accept & w_legal;
    assign w_pop       = instr_valid & instr_ready;

    // Head word while occupied; otherwise the most recently popped word.
    assign instr     = instr_valid ? r_mem[r_rd_ptr] : r_last;
    assign err       = r_err;
    assign enc_count = r_enc_count;
    assign err_count = r_err_count;

    // FIFO storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // FIFO pointers, occupancy and last-popped word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= 32'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Error pulse and saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err       <= 1'b0;
            r_enc_count <= '0;
            r_err_count <= '0;
        end else begin
            r_err <= w_accept & ~w_legal;
            if (w_push && (r_enc_count != c_CNT_MAX)) begin
                r_enc_count <= r_enc_count + CNT_W'(1);
            end
            if (w_accept && !w_legal && (r_err_count != c_CNT_MAX)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder: directed examples,
//               full-FIFO backpressure, randomized traffic against a
//               queue-based reference model, and reset mid-operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_fmt;
    logic [4:0]       cmd_rd;
    logic [4:0]       cmd_rs1;
    logic [4:0]       cmd_rs2;
    logic [2:0]       cmd_funct3;
    logic [6:0]       cmd_funct7;
    logic [31:0]      cmd_imm;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic             err;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    int n_checks = 0;
    int n_errors = 0;

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_fmt     (cmd_fmt),
        .cmd_rd      (cmd_rd),
        .cmd_rs1     (cmd_rs1),
        .cmd_rs2     (cmd_rs2),
        .cmd_funct3  (cmd_funct3),
        .cmd_funct7  (cmd_funct7),
        .cmd_imm     (cmd_imm),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .err         (err),
        .enc_count   (enc_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: field extraction by shifting/masking plain integers and
    // legality by signed range arithmetic.
    function automatic bit [31:0] m_encode(input int fmt, input int rd, input int rs1,
                                           input int rs2, input int f3, input int f7,
                                           input bit [31:0] imm, output bit ok);
        bit [6:0] ops [11] = '{7'h33, 7'h67, 7'h03, 7'h13, 7'h73, 7'h0F,
                               7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        int signed s;
        bit [31:0] op;
        bit [31:0] regs;
        s  = imm;
        ok = 1'b0;
        if (fmt > 10) return 32'd0;
        op   = 32'(ops[fmt]);
        regs = (32'(rs1) << 15) | (32'(f3) << 12);
        if (fmt == 0) begin
            ok = 1'b1;
            return (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7) | op;
        end else if (fmt <= 5) begin
            ok = (s >= -2048) && (s <= 2047);
            return ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7) | op;
        end else if (fmt == 6) begin
            ok = (s >= -2048) && (s <= 2047);
            return (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs |
                   ((imm & 32'h1F) << 7) | op;
        end else if (fmt == 7) begin
            ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
            return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                   (32'(rs2) << 20) | regs | (((imm >> 1) & 32'hF) << 8) |
                   (((imm >> 11) & 1) << 7) | op;
        end else if (fmt <= 9) begin
            ok = (imm % 4096) == 0;
            return (imm & 32'hFFFF_F000) | (32'(rd) << 7) | op;
        end else begin
            ok = (s >= -(1 << 20)) && (s < (1 << 20)) && (s % 2 == 0);
            return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                   (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
                   (32'(rd) << 7) | op;
        end
    endfunction

    // Model state describing the DUT after the most recent rising edge.
    bit [31:0] m_q[$];
    bit [31:0] m_last    = 0;
    bit        m_err     = 0;
    int        m_enc_cnt = 0;
    int        m_err_cnt = 0;
    bit        m_on      = 0;
    int        c_max     = (1 << CNT_W) - 1;

    // Compare on the falling edge, then advance the model by the coming edge.
    always @(negedge clk) begin
        bit        ok;
        bit [31:0] word;
        bit        acc;
        if (m_on) begin
            chk("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
            chk("cmd_ready", 32'(cmd_ready), 32'(m_q.size() < DEPTH));
            if (m_q.size() != 0) chk("instr_head", instr, m_q[0]);
            else                 chk("instr_idle", instr, m_last);
            chk("err", 32'(err), 32'(m_err));
            chk("enc_count", 32'(enc_count), 32'(m_enc_cnt));
            chk("err_count", 32'(err_count), 32'(m_err_cnt));
        end
        if (rst) begin
            m_q.delete();
            m_last = 0; m_err = 0; m_enc_cnt = 0; m_err_cnt = 0; m_on = 1;
        end else if (m_on) begin
            acc  = cmd_valid && (m_q.size() < DEPTH);
            word = m_encode(int'(cmd_fmt), int'(cmd_rd), int'(cmd_rs1), int'(cmd_rs2),
                            int'(cmd_funct3), int'(cmd_funct7), cmd_imm, ok);
            if (m_q.size() != 0 && instr_ready) m_last = m_q.pop_front();
            m_err = acc && !ok;
            if (acc && ok) begin
                m_q.push_back(word);
                if (m_enc_cnt < c_max) m_enc_cnt++;
            end
            if (acc && !ok && m_err_cnt < c_max) m_err_cnt++;
        end
    end

    // Present a command and hold it until the handshake edge has passed.
    task automatic send(input int fmt, input int rd, input int rs1, input int rs2,
                        input int f3, input int f7, input bit [31:0] imm);
        int waited = 0;
        cmd_valid  = 1'b1;
        cmd_fmt    = 4'(fmt);
        cmd_rd     = 5'(rd);
        cmd_rs1    = 5'(rs1);
        cmd_rs2    = 5'(rs2);
        cmd_funct3 = 3'(f3);
        cmd_funct7 = 7'(f7);
        cmd_imm    = imm;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            waited++;
            if (waited > 50) begin
                n_checks++; n_errors++;
                $display("FAIL send_timeout: cmd_ready stuck at 0 for %0d cycles", waited);
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic pop_one();
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        rst = 1'b1; cmd_valid = 1'b0; instr_ready = 1'b0;
        cmd_fmt = 0; cmd_rd = 0; cmd_rs1 = 0; cmd_rs2 = 0;
        cmd_funct3 = 0; cmd_funct7 = 0; cmd_imm = 0;

        // Pin the reference model to hand-computed words.
        chk("model_addi", m_encode(3, 1, 0, 0, 0, 0, 32'd5, ok), 32'h0050_0093);
        chk("model_add", m_encode(0, 3, 1, 2, 0, 0, 32'd0, ok), 32'h0020_81B3);
        chk("model_beq", m_encode(7, 0, 1, 2, 0, 0, 32'hFFFF_FFFC, ok), 32'hFE20_8EE3);
        chk("model_lui", m_encode(8, 5, 0, 0, 0, 0, 32'h1234_5000, ok), 32'h1234_52B7);
        void'(m_encode(10, 0, 0, 0, 0, 0, 32'd3, ok));
        chk("model_j_odd_illegal", 32'(ok), 32'd0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_enc_count", 32'(enc_count), 32'd0);

        // Directed encodings, each visible the cycle after acceptance.
        send(3, 1, 0, 0, 0, 0, 32'd5);
        chk("ex_addi", instr, 32'h0050_0093);
        chk("ex_addi_valid", 32'(instr_valid), 32'd1);
        chk("ex_addi_cnt", 32'(enc_count), 32'd1);
        pop_one();
        send(0, 3, 1, 2, 0, 0, 32'd0);
        chk("ex_add", instr, 32'h0020_81B3);
        pop_one();
        send(7, 0, 1, 2, 0, 0, 32'hFFFF_FFFC);
        chk("ex_beq", instr, 32'hFE20_8EE3);
        pop_one();
        send(8, 5, 0, 0, 0, 0, 32'h1234_5000);
        chk("ex_lui", instr, 32'h1234_52B7);
        pop_one();
        chk("idle_holds_last", instr, 32'h1234_52B7);

        // Two illegal commands back to back.
        send(10, 0, 0, 0, 0, 0, 32'd3);
        chk("ill1_err", 32'(err), 32'd1);
        send(13, 0, 0, 0, 0, 0, 32'd0);
        chk("ill2_err", 32'(err), 32'd1);
        chk("ill_err_count", 32'(err_count), 32'd2);
        chk("ill_no_valid", 32'(instr_valid), 32'd0);
        @(posedge clk); #1;
        chk("ill_err_drop", 32'(err), 32'd0);

        // Fill the FIFO, then release while the fifth command waits.
        for (int k = 1; k <= 4; k++) send(3, k, 0, 0, 0, 0, 32'(k));
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        instr_ready = 1'b1;
        send(3, 5, 0, 0, 0, 0, 32'd5);
        repeat (8) @(posedge clk);
        #1;
        chk("drain_empty", 32'(instr_valid), 32'd0);
        chk("drain_last", instr, 32'h0050_0293);
        instr_ready = 1'b0;

        // Randomized traffic; the compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            cmd_valid   = ($urandom_range(0, 99) < 60);
            instr_ready = ($urandom_range(0, 99) < 55);
            cmd_fmt     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15))
                                                      : 4'($urandom_range(0, 10));
            cmd_rd      = 5'($urandom);
            cmd_rs1     = 5'($urandom);
            cmd_rs2     = 5'($urandom);
            cmd_funct3  = 3'($urandom);
            cmd_funct7  = 7'($urandom);
            case ($urandom_range(0, 4))
                0: cmd_imm = 32'(int'($urandom_range(0, 4095)) - 2048);
                1: cmd_imm = $urandom & 32'hFFFF_F000;
                2: cmd_imm = 32'(int'($urandom_range(0, 8191)) - 4096) & 32'hFFFF_FFFE;
                3: cmd_imm = 32'(int'($urandom_range(0, 2097151)) - 1048576) & 32'hFFFF_FFFE;
                default: cmd_imm = $urandom;
            endcase
        end
        cmd_valid = 1'b0;
        instr_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        instr_ready = 1'b0;

        // Reset with three entries queued.
        for (int k = 0; k < 3; k++) send(6, 0, 2, 3, 2, 0, 32'(k * 4));
        chk("pre_rst_valid", 32'(instr_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_instr", instr, 32'd0);
        chk("midrst_enc_count", 32'(enc_count), 32'd0);
        chk("midrst_err_count", 32'(err_count), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(instr_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
